// File: rtl/anita3_event_readout_ctrl.sv
// anita3_event_readout_ctrl: reads one 64-word event from the dual event
// buffer on the 33 MHz side and streams it out over valid/ready.
// Two clear pulses go to the buffer manager: after words 0..HALF-1 and
// after words HALF..2*HALF-1. A holdoff then lets the 250 MHz round trip
// settle before the buffer is sampled again.
// Ports:
//   clk33_i, rst_i      clock, synchronous active-high reset
//   enable_i            start gate, sampled only while idle
//   buffer_valid_i      an event is waiting in the buffer
//   read_buffer_i       current read buffer (bit 0 = RAM half)
//   event_rd_addr_o     RAM word address (data one cycle later)
//   event_rd_dat_i      RAM read data
//   clear_evt_o         one-cycle clear pulse
//   out_dat_o/valid/ready/first/last   readout stream
//   out_buffer_o        buffer index of the event being read
//   event_count_o       completed events (wraps)
//   busy_o              not idle
module anita3_event_readout_ctrl #(
  parameter int HALF_WORDS  = 32,
  parameter int CLR_HOLDOFF = 8
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        buffer_valid_i,
  input  logic [1:0]  read_buffer_i,
  output logic [5:0]  event_rd_addr_o,
  input  logic [31:0] event_rd_dat_i,
  output logic        clear_evt_o,
  output logic [31:0] out_dat_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_first_o,
  output logic        out_last_o,
  output logic        out_buffer_o,
  output logic [15:0] event_count_o,
  output logic        busy_o
);

  localparam int HW = $clog2(CLR_HOLDOFF + 1);
  localparam logic [6:0] LP_HALF = 7'(HALF_WORDS);
  localparam logic [6:0] LP_FULL = 7'(2 * HALF_WORDS);
  localparam logic [6:0] LP_LAST = 7'(2 * HALF_WORDS - 1);
  localparam logic [HW-1:0] LP_HOLD = HW'(CLR_HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE, S_READ0, S_CLR0, S_READ1, S_CLR1, S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [6:0]    r_issue;
  logic [6:0]    r_acc;
  logic          r_inflight;
  logic [5:0]    r_addr;
  logic [31:0]   r_sk0;
  logic [31:0]   r_sk1;
  logic [1:0]    r_sk_cnt;
  logic          r_buf;
  logic [15:0]   r_evt_cnt;
  logic [HW-1:0] r_hold;

  logic       w_start;
  logic       w_pop;
  logic       w_can_issue;
  logic       w_issue;
  logic [1:0] w_occ;
  logic       w_unused;

  assign w_unused = read_buffer_i[1];

  assign out_valid_o = (r_sk_cnt != 2'd0);
  assign w_pop       = out_valid_o && out_ready_i;

  // Skid occupancy after this cycle, counting the word still in the RAM.
  // Issue only if that word is guaranteed a free slot even with no pop.
  assign w_occ = 2'(r_sk_cnt + {1'b0, r_inflight} - {1'b0, w_pop});

  assign w_can_issue =
    ((r_state == S_READ0) && (r_issue < LP_HALF)) ||
    ((r_state == S_READ1) && (r_issue < LP_FULL));
  assign w_issue = w_can_issue && (w_occ <= 2'd1);

  // Address goes out in the issue cycle so data lands next cycle.
  assign event_rd_addr_o = w_issue ? r_issue[5:0] : r_addr;

  // Skid head is always word r_acc of the event.
  assign out_dat_o     = r_sk0;
  assign out_first_o   = out_valid_o && (r_acc == 7'd0);
  assign out_last_o    = out_valid_o && (r_acc == LP_LAST);
  assign out_buffer_o  = r_buf;
  assign event_count_o = r_evt_cnt;
  assign clear_evt_o   = (r_state == S_CLR0) || (r_state == S_CLR1);
  assign busy_o        = (r_state != S_IDLE);

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable_i && buffer_valid_i) begin
          w_next  = S_READ0;
          w_start = 1'b1;
        end
      end
      S_READ0: begin
        if (w_pop && (r_acc == LP_HALF - 7'd1))
          w_next = S_CLR0;
      end
      S_CLR0:  w_next = S_READ1;
      S_READ1: begin
        if (w_pop && (r_acc == LP_LAST))
          w_next = S_CLR1;
      end
      S_CLR1:  w_next = S_HOLD;
      S_HOLD: begin
        if (r_hold <= HW'(1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_issue    <= 7'd0;
      r_acc      <= 7'd0;
      r_inflight <= 1'b0;
      r_addr     <= 6'd0;
      r_sk0      <= 32'd0;
      r_sk1      <= 32'd0;
      r_sk_cnt   <= 2'd0;
      r_buf      <= 1'b0;
      r_evt_cnt  <= 16'd0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_next;
      r_addr     <= event_rd_addr_o;
      r_inflight <= w_issue;

      if (w_start) begin
        r_buf   <= read_buffer_i[0];
        r_issue <= 7'd0;
        r_acc   <= 7'd0;
      end else begin
        if (w_issue) r_issue <= r_issue + 7'd1;
        if (w_pop)   r_acc   <= r_acc + 7'd1;
      end

      unique case ({r_inflight, w_pop})
        2'b10: begin
          if (r_sk_cnt == 2'd0) r_sk0 <= event_rd_dat_i;
          else                  r_sk1 <= event_rd_dat_i;
          r_sk_cnt <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk0    <= r_sk1;
          r_sk_cnt <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          if (r_sk_cnt == 2'd1) begin
            r_sk0 <= event_rd_dat_i;
          end else begin
            r_sk0 <= r_sk1;
            r_sk1 <= event_rd_dat_i;
          end
        end
        default: ;
      endcase

      // Count moves with the second clear so both are seen together.
      if ((r_state == S_READ1) && (w_next == S_CLR1))
        r_evt_cnt <= r_evt_cnt + 16'd1;

      if (r_state == S_CLR1)
        r_hold <= LP_HOLD;
      else if ((r_state == S_HOLD) && (r_hold != '0))
        r_hold <= r_hold - HW'(1);
    end
  end

endmodule

// File: tb/tb_anita3_event_readout_ctrl.sv
// tb_anita3_event_readout_ctrl: randomized bench for the event readout
// controller with a RAM model and an event-level reference model.
module tb_anita3_event_readout_ctrl;

  localparam int HALF = 32;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        buffer_valid_i;
  logic [1:0]  read_buffer_i;
  logic [5:0]  event_rd_addr_o;
  logic [31:0] event_rd_dat_i;
  logic        clear_evt_o;
  logic [31:0] out_dat_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_first_o;
  logic        out_last_o;
  logic        out_buffer_o;
  logic [15:0] event_count_o;
  logic        busy_o;

  anita3_event_readout_ctrl #(
    .HALF_WORDS (HALF),
    .CLR_HOLDOFF(8)
  ) dut (
    .clk33_i        (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .buffer_valid_i (buffer_valid_i),
    .read_buffer_i  (read_buffer_i),
    .event_rd_addr_o(event_rd_addr_o),
    .event_rd_dat_i (event_rd_dat_i),
    .clear_evt_o    (clear_evt_o),
    .out_dat_o      (out_dat_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_first_o    (out_first_o),
    .out_last_o     (out_last_o),
    .out_buffer_o   (out_buffer_o),
    .event_count_o  (event_count_o),
    .busy_o         (busy_o)
  );

  always #15 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RAM: bit 0 of the read buffer picks the half, one cycle latency.
  logic [31:0] mem [2][64];
  always @(posedge clk)
    event_rd_dat_i <= mem[read_buffer_i[0]][event_rd_addr_o];

  bit rdy_rand = 1'b0;
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model: event = 64 words mem[b][0..63] in order, clears
  // after word HALF-1 and after the last word, count +1 per event.
  bit          buf_q[$];
  int          widx = 0;
  int          clr_seen = 0;
  int          events_done = 0;
  int          gap = 1000;
  int          lat = 0;
  bit          lat_arm = 1'b0;
  bit          busy_p = 1'b0;
  bit          stall_p = 1'b0;
  logic [31:0] dat_p = '0;
  logic [15:0] ev_model = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      widx     = 0;
      clr_seen = 0;
      gap      = 1000;
      lat_arm  = 1'b0;
      busy_p   = 1'b0;
      stall_p  = 1'b0;
      ev_model = '0;
    end else begin
      gap++;
      if (stall_p) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_dat", out_dat_o, dat_p);
      end
      if (out_valid_o && out_ready_i) begin
        chk("xfer_ok", 32'(widx < 64 && buf_q.size() > 0), 32'd1);
        if (widx < 64 && buf_q.size() > 0) begin
          chk("dat", out_dat_o, mem[buf_q[0]][widx]);
          chk("first", 32'(out_first_o), 32'(widx == 0));
          chk("last", 32'(out_last_o), 32'(widx == 63));
          chk("buf", 32'(out_buffer_o), 32'(buf_q[0]));
        end
        widx++;
      end
      if (clear_evt_o) begin
        chk("clr_gap", 32'(gap > HALF), 32'd1);
        gap = 0;
        chk("clr_pos", 32'(widx), (clr_seen == 0) ? HALF : 2 * HALF);
        clr_seen++;
        if (clr_seen == 2) begin
          ev_model++;
          chk("evt_count", 32'(event_count_o), 32'(ev_model));
          widx     = 0;
          clr_seen = 0;
          events_done++;
          if (buf_q.size() > 0) buf_q.delete(0);
        end
      end
      if (busy_o && !busy_p) begin
        lat     = 0;
        lat_arm = 1'b1;
      end else if (lat_arm) begin
        lat++;
        if (out_valid_o) begin
          chk("first_lat", 32'(lat), 32'd2);
          lat_arm = 1'b0;
        end
      end
      busy_p  = busy_o;
      stall_p = out_valid_o && !out_ready_i;
      dat_p   = out_dat_o;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (events_done < target && n < budget) begin
      step();
      n++;
    end
    chk("done_in_time", 32'(events_done >= target), 32'd1);
  endtask

  task automatic wait_widx(input int target, input int budget);
    int n = 0;
    while (widx < target && n < budget) begin
      step();
      n++;
    end
    chk("widx_in_time", 32'(widx >= target), 32'd1);
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++)
        mem[b][i] = $urandom();
  endtask

  initial begin
    bit          bad_busy;
    bit          bad_addr;
    logic [5:0]  a0;
    int          ev0;

    rst_i          = 1'b1;
    enable_i       = 1'b0;
    buffer_valid_i = 1'b0;
    read_buffer_i  = 2'd0;
    fill_rand();
    for (int i = 0; i < 64; i++) mem[0][i] = 32'hA500_0000 + 32'(i);

    repeat (3) step();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_clr", 32'(clear_evt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_count", 32'(event_count_o), 32'd0);
    chk("rst_addr", 32'(event_rd_addr_o), 32'd0);
    chk("rst_dat", out_dat_o, 32'd0);
    chk("rst_flags", 32'({out_first_o, out_last_o, out_buffer_o}), 32'd0);
    rst_i = 1'b0;
    step();

    // Single event, buffer 0, ready held high.
    buf_q.push_back(1'b0);
    enable_i       = 1'b1;
    buffer_valid_i = 1'b1;
    wait_done(1, 2000);
    buffer_valid_i = 1'b0;
    repeat (12) step();
    chk("t1_count", 32'(event_count_o), 32'd1);

    // Same event under random backpressure.
    rdy_rand = 1'b1;
    buf_q.push_back(1'b0);
    buffer_valid_i = 1'b1;
    wait_done(2, 4000);
    buffer_valid_i = 1'b0;
    repeat (12) step();
    chk("t2_count", 32'(event_count_o), 32'd2);

    // Back-to-back: buffer 0 then buffer 1.
    fill_rand();
    buf_q.push_back(1'b0);
    buf_q.push_back(1'b1);
    read_buffer_i  = 2'd0;
    buffer_valid_i = 1'b1;
    wait_done(3, 4000);
    read_buffer_i = 2'd1;
    wait_done(4, 4000);
    buffer_valid_i = 1'b0;
    repeat (12) step();
    chk("t3_count", 32'(event_count_o), 32'd4);

    // Reset mid-event, once in each half.
    rdy_rand = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int ab;
      ab = (k == 0) ? 20 : 40;
      fill_rand();
      read_buffer_i = 2'(k);
      buf_q.push_back(1'(k));
      ev0 = events_done;
      buffer_valid_i = 1'b1;
      wait_widx(ab, 2000);
      chk("abort_clrs", 32'(clr_seen), (ab >= HALF) ? 32'd1 : 32'd0);
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      wait_done(ev0 + 1, 4000);
      buffer_valid_i = 1'b0;
      repeat (12) step();
      chk("abort_count", 32'(event_count_o), 32'd1);
    end

    // Enable gating.
    rdy_rand = 1'b1;
    fill_rand();
    read_buffer_i  = 2'd1;
    enable_i       = 1'b0;
    buffer_valid_i = 1'b1;
    a0       = event_rd_addr_o;
    bad_busy = 1'b0;
    bad_addr = 1'b0;
    repeat (30) begin
      step();
      if (busy_o) bad_busy = 1'b1;
      if (event_rd_addr_o != a0) bad_addr = 1'b1;
    end
    chk("gate_busy", 32'(bad_busy), 32'd0);
    chk("gate_addr", 32'(bad_addr), 32'd0);
    ev0 = events_done;
    buf_q.push_back(1'b1);
    enable_i = 1'b1;
    wait_widx(10, 2000);
    enable_i = 1'b0;
    wait_done(ev0 + 1, 4000);
    repeat (30) step();
    chk("gate_idle", 32'(busy_o), 32'd0);
    chk("gate_events", 32'(events_done), 32'(ev0 + 1));
    chk("gate_count", 32'(event_count_o), 32'd2);

    // Counter wrap.
    buffer_valid_i = 1'b0;
    step();
    force dut.r_evt_cnt = 16'hFFFF;
    step();
    release dut.r_evt_cnt;
    ev_model = 16'hFFFF;
    step();
    chk("wrap_pre", 32'(event_count_o), 32'h0000_FFFF);
    ev0 = events_done;
    read_buffer_i = 2'd0;
    buf_q.push_back(1'b0);
    enable_i       = 1'b1;
    buffer_valid_i = 1'b1;
    wait_done(ev0 + 1, 4000);
    buffer_valid_i = 1'b0;
    repeat (12) step();
    chk("wrap_count", 32'(event_count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
